// File: rtl/instr_encoder.sv
// instr_encoder: RV32I encoder/loader for bne, jal, jalr, addi, slli, lw, sw
//   in:  clk, rst_n (async active-low), start (restart load),
//        in_valid/op/rd/rs1/rs2/imm (request)
//   out: in_ready, mem_we/mem_addr/mem_wdata (imem write port),
//        count (words written), full (count == DEPTH), err (sticky reject)
module instr_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, ENC, WR} state_t;
  localparam logic [ADDR_WIDTH:0]   DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
  state_t                  r_state, w_next;
  logic [2:0]              r_op;
  logic [4:0]              r_rd, r_rs1, r_rs2;
  logic [31:0]             r_imm;
  logic                    r_we, r_full, r_err;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [ADDR_WIDTH:0]     r_count;
  logic [ADDR_WIDTH:0]     w_count_nxt;
  logic signed [31:0]      w_simm;
  logic                    w_acc, w_i12, w_b13, w_j21, w_sh, w_legal;
  logic [31:0]             w_word;
  assign in_ready    = (r_state == IDLE) && !r_full && !start;
  assign w_acc       = in_valid && in_ready;
  assign w_count_nxt = r_count + 1'b1;
  assign w_simm      = r_imm;
  // Branch/jump offsets are byte offsets that must stay halfword aligned.
  assign w_i12 = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
  assign w_b13 = !r_imm[0] && (w_simm >= -32'sd4096) && (w_simm <= 32'sd4094);
  assign w_j21 = !r_imm[0] && (w_simm >= -32'sd1048576) && (w_simm <= 32'sd1048574);
  // Unsigned compare also rejects negative shift amounts.
  assign w_sh  = r_imm <= 32'd31;
  always_comb begin
    w_legal = 1'b0;
    w_word  = '0;
    case (r_op)
      3'd0: begin
        w_legal = w_b13;
        w_word  = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, 3'b001, r_imm[4:1], r_imm[11], 7'b1100011};
      end
      3'd1: begin
        w_legal = w_j21;
        w_word  = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, 7'b1101111};
      end
      3'd2: begin
        w_legal = w_i12;
        w_word  = {r_imm[11:0], r_rs1, 3'b000, r_rd, 7'b1100111};
      end
      3'd3: begin
        w_legal = w_i12;
        w_word  = {r_imm[11:0], r_rs1, 3'b000, r_rd, 7'b0010011};
      end
      3'd4: begin
        w_legal = w_sh;
        w_word  = {7'b0, r_imm[4:0], r_rs1, 3'b001, r_rd, 7'b0010011};
      end
      3'd5: begin
        w_legal = w_i12;
        w_word  = {r_imm[11:0], r_rs1, 3'b010, r_rd, 7'b0000011};
      end
      3'd6: begin
        w_legal = w_i12;
        w_word  = {r_imm[11:5], r_rs2, r_rs1, 3'b010, r_imm[4:0], 7'b0100011};
      end
      default: begin
        w_legal = 1'b0;
        w_word  = '0;
      end
    endcase
  end
  always_comb begin
    w_next = start ? IDLE :
             (r_state == IDLE) ? (w_acc ? ENC : IDLE) :
             (r_state == ENC && w_legal) ? WR : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_imm   <= '0;
      r_we    <= 1'b0;
      r_addr  <= BASE;
      r_wdata <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else if (start) begin
      r_we    <= 1'b0;
      r_addr  <= BASE;
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_op  <= op;
        r_rd  <= rd;
        r_rs1 <= rs1;
        r_rs2 <= rs2;
        r_imm <= imm;
      end
      if (r_state == ENC) begin
        if (w_legal) begin
          r_wdata <= DATA_WIDTH'(w_word);
          r_we    <= 1'b1;
        end else begin
          r_err   <= 1'b1;
        end
      end
      if (r_state == WR) begin
        r_we    <= 1'b0;
        r_addr  <= r_addr + 1'b1;
        r_count <= w_count_nxt;
        r_full  <= w_count_nxt == DEPTH;
      end
    end
  end
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign count     = r_count;
  assign full      = r_full;
  assign err       = r_err;
endmodule
